// File: rtl/dram_pkg.sv
// Shared types for the 68040 DRAM controller: SIZ encodings, FSM states and the
// byte-lane decode used to drive the per-lane CAS strobes.
package dram_pkg;

  typedef enum logic [1:0] {
    SIZ_LONG = 2'b00,
    SIZ_BYTE = 2'b01,
    SIZ_WORD = 2'b10,
    SIZ_LINE = 2'b11
  } siz_e;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCol,
    StCpre,
    StPre,
    StRefCas,
    StRefRas
  } state_e;

  // Active-low CAS lanes; lane 3 is D31-D24 (big-endian byte 0).
  function automatic logic [3:0] lane_mask(logic [1:0] siz, logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (siz)
      SIZ_BYTE: m = ~(4'b1000 >> a);
      SIZ_WORD: m = a[1] ? 4'b1100 : 4'b0011;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dram_controller_if.sv
// CPU-side request and DRAM-side strobe signals of the DRAM controller.
interface dram_controller_if #(
  parameter int unsigned ROW_BITS = 10,
  parameter int unsigned COL_BITS = 10
);
  localparam int unsigned MA_BITS = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
  localparam int unsigned A_BITS  = ROW_BITS + COL_BITS + 4;

  logic                ts;
  logic                dramsel;
  logic                rw;
  logic [1:0]          siz;
  logic [A_BITS-1:0]   a;
  logic [MA_BITS-1:0]  ma;
  logic [3:0]          ras;
  logic [3:0]          cas;
  logic                we;
  logic                ta;
  logic                busy;

  modport master (
    output ts, dramsel, rw, siz, a,
    input  ma, ras, cas, we, ta, busy
  );

  modport slave (
    input  ts, dramsel, rw, siz, a,
    output ma, ras, cas, we, ta, busy
  );
endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a single saturating pending flag.
module dram_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 390
) (
  input  logic bclk,
  input  logic rst,
  input  logic ack,
  output logic req
);
  localparam int unsigned CntW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            pending_q;
  logic            expire;

  assign expire = (cnt_q == '0);
  // Expiry is visible in the same cycle so IDLE can favour refresh over a coincident TS.
  assign req    = pending_q | expire;

  always_ff @(posedge bclk) begin
    if (rst) begin
      cnt_q     <= CntW'(REFRESH_CYCLES - 1);
      pending_q <= 1'b0;
    end else if (expire) begin
      cnt_q     <= CntW'(REFRESH_CYCLES - 1);
      pending_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q - 1'b1;
      if (ack) pending_q <= 1'b0;
    end
  end
endmodule

// File: rtl/dram_controller.sv
// 68040 bus responder for the DRAM array: row/column multiplexing, page-mode line
// bursts and CAS-before-RAS refresh. All strobes are registered from the current state.
module dram_controller
  import dram_pkg::*;
#(
  parameter int unsigned ROW_BITS       = 10,
  parameter int unsigned COL_BITS       = 10,
  parameter int unsigned T_RCD          = 1,
  parameter int unsigned T_CAS          = 2,
  parameter int unsigned T_RP           = 2,
  parameter int unsigned REFRESH_CYCLES = 390
) (
  input logic               bclk,
  input logic               rst,
  dram_controller_if.slave  bus
);
  localparam int unsigned MA_BITS = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
  localparam int unsigned A_BITS  = ROW_BITS + COL_BITS + 4;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] beat_q, beat_d, nbeat_q, nbeat_d;

  logic              lat_valid_q, lat_rw_q, lat_clr;
  logic [1:0]        lat_siz_q;
  logic [A_BITS-1:0] lat_a_q;
  logic              ts_hit, ref_req, ref_ack, last_beat;

  logic [1:0]          bank;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col_beat;
  logic [3:0]          ras_bank;

  logic [MA_BITS-1:0] ma_q, ma_d;
  logic [3:0]         ras_q, ras_d, cas_q, cas_d;
  logic               we_q, we_d, ta_q, ta_d, busy_q;

  assign ts_hit    = !bus.ts && bus.dramsel;
  assign bank      = lat_a_q[A_BITS-1 -: 2];
  assign row       = lat_a_q[COL_BITS+2 +: ROW_BITS];
  assign col_beat  = {lat_a_q[COL_BITS+1:4], beat_q};
  assign ras_bank  = ~(4'b0001 << bank);
  assign last_beat = (lat_siz_q != SIZ_LINE) || (nbeat_q == 2'd3);

  dram_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .bclk(bclk),
    .rst (rst),
    .ack (ref_ack),
    .req (ref_req)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    nbeat_d = nbeat_q;
    lat_clr = 1'b0;
    ref_ack = 1'b0;
    ma_d    = ma_q;
    ras_d   = 4'hF;
    cas_d   = 4'hF;
    we_d    = 1'b1;
    ta_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (ref_req) begin
          state_d = StRefCas;
        end else if (lat_valid_q || ts_hit) begin
          state_d = StRow;
          cnt_d   = 8'(T_RCD - 1);
        end
      end
      StRow: begin
        ras_d   = ras_bank;
        ma_d    = MA_BITS'(row);
        we_d    = lat_rw_q;
        beat_d  = lat_a_q[3:2];
        nbeat_d = 2'd0;
        if (cnt_q == '0) begin
          state_d = StCol;
          cnt_d   = 8'(T_CAS - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCol: begin
        ras_d = ras_bank;
        ma_d  = MA_BITS'(col_beat);
        cas_d = lane_mask(lat_siz_q, lat_a_q[1:0]);
        we_d  = lat_rw_q;
        if (cnt_q == '0) begin
          ta_d = 1'b0;
          if (last_beat) begin
            state_d = StPre;
            cnt_d   = 8'(T_RP - 1);
            lat_clr = 1'b1;
          end else begin
            state_d = StCpre;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCpre: begin
        ras_d   = ras_bank;
        we_d    = lat_rw_q;
        beat_d  = beat_q + 2'd1;
        nbeat_d = nbeat_q + 2'd1;
        state_d = StCol;
        cnt_d   = 8'(T_CAS - 1);
      end
      StPre: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 8'd1;
      end
      StRefCas: begin
        cas_d   = 4'h0;
        ref_ack = 1'b1;
        state_d = StRefRas;
        cnt_d   = 8'(T_CAS);
      end
      StRefRas: begin
        cas_d = 4'h0;
        ras_d = 4'h0;
        if (cnt_q == '0) begin
          state_d = StPre;
          cnt_d   = 8'(T_RP - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      nbeat_q <= '0;
      ma_q    <= '0;
      ras_q   <= 4'hF;
      cas_q   <= 4'hF;
      we_q    <= 1'b1;
      ta_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      nbeat_q <= nbeat_d;
      ma_q    <= ma_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      we_q    <= we_d;
      ta_q    <= ta_d;
      busy_q  <= (state_q != StIdle);
    end
  end

  // A request captured during PRE or refresh waits here until IDLE picks it up.
  always_ff @(posedge bclk) begin
    if (rst) begin
      lat_valid_q <= 1'b0;
      lat_rw_q    <= 1'b1;
      lat_siz_q   <= '0;
      lat_a_q     <= '0;
    end else if (lat_clr) begin
      lat_valid_q <= 1'b0;
    end else if (ts_hit && !lat_valid_q) begin
      lat_valid_q <= 1'b1;
      lat_rw_q    <= bus.rw;
      lat_siz_q   <= bus.siz;
      lat_a_q     <= bus.a;
    end
  end

  assign bus.ma   = ma_q;
  assign bus.ras  = ras_q;
  assign bus.cas  = cas_q;
  assign bus.we   = we_q;
  assign bus.ta   = ta_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_dram_controller.sv
// Scoreboard bench for dram_controller: each TA beat is checked against a queued
// expectation, strobe timing is checked by directed cycle-by-cycle vectors.
module tb_dram_controller;
  localparam int unsigned T_RP = 2;

  logic bclk = 1'b0;
  logic rst  = 1'b1;

  dram_controller_if #(.ROW_BITS(10), .COL_BITS(10)) bus ();

  dram_controller #(
    .ROW_BITS      (10),
    .COL_BITS      (10),
    .T_RCD         (1),
    .T_CAS         (2),
    .T_RP          (T_RP),
    .REFRESH_CYCLES(390)
  ) dut (
    .bclk(bclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 bclk = ~bclk;

  typedef struct packed {
    logic [9:0] ma;
    logic [3:0] cas;
    logic [3:0] ras;
    logic       we;
  } beat_t;

  beat_t sb_q[$];
  beat_t mon_got, mon_exp;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    hi_cnt = 100;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] mk_addr(logic [1:0] bank, logic [9:0] row, logic [9:0] col,
                                          logic [1:0] lane);
    return {bank, row, col, lane};
  endfunction

  task automatic push(input logic [9:0] ma, input logic [3:0] cas, input logic [3:0] ras,
                      input logic we);
    beat_t b;
    b.ma  = ma;
    b.cas = cas;
    b.ras = ras;
    b.we  = we;
    sb_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge bclk);
    rst         = 1'b1;
    bus.ts      = 1'b1;
    bus.dramsel = 1'b0;
    repeat (2) @(negedge bclk);
    rst = 1'b0;
  endtask

  // Caller is at a negedge; TS is sampled at the following rising edge (edge 0).
  task automatic issue(input logic [23:0] addr, input logic [1:0] siz, input logic rw);
    bus.a       = addr;
    bus.siz     = siz;
    bus.rw      = rw;
    bus.ts      = 1'b0;
    bus.dramsel = 1'b1;
    @(negedge bclk);
    bus.ts      = 1'b1;
    bus.dramsel = 1'b0;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((sb_q.size() != 0 || bus.busy !== 1'b0) && i < 80) begin
      @(negedge bclk);
      i++;
    end
    chk({name, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every TA beat must match the oldest expectation; RAS high time is policed.
  always @(negedge bclk) begin
    if (bus.ta === 1'b0) begin
      mon_got.ma  = bus.ma;
      mon_got.cas = bus.cas;
      mon_got.ras = bus.ras;
      mon_got.we  = bus.we;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ta: got TA=0 (ras %b cas %b), required no TA", bus.ras,
                 bus.cas);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("ta_beat", 32'(mon_got), 32'(mon_exp));
      end
    end
    if (bus.ras === 4'hF) begin
      hi_cnt++;
    end else begin
      if (hi_cnt > 0) begin
        n_chk++;
        if (hi_cnt < int'(T_RP)) begin
          n_fail++;
          $display("FAIL ras_precharge: got %0d high cycles, required >= %0d", hi_cnt, T_RP);
        end
      end
      hi_cnt = 0;
    end
  end

  // {ras, cas, we, busy} after edges 1..6 of a byte write to bank 1, lane 2 (D15-D8).
  logic [9:0] bw_exp [1:6] = '{10'b1101_1111_0_1, 10'b1101_1101_0_1, 10'b1101_1101_0_1,
                                10'b1111_1111_1_1, 10'b1111_1111_1_1, 10'b1111_1111_1_0};

  // {siz, lane, expected cas} for single transfers to bank 2.
  logic [7:0] st_tab [4] = '{{2'b01, 2'b00, 4'b0111}, {2'b01, 2'b11, 4'b1110},
                             {2'b10, 2'b01, 4'b0011}, {2'b10, 2'b11, 4'b1100}};

  initial begin
    logic [23:0] a;
    logic [3:0]  prev_cas;
    int          k, ras_lo, cas_falls, tcnt, extra;

    bus.ts = 1'b1; bus.dramsel = 1'b0; bus.rw = 1'b1; bus.siz = 2'b00; bus.a = '0;

    // Reset state
    do_reset();
    chk("reset_strobes", 32'({bus.ras, bus.cas, bus.we, bus.ta}), 32'({4'hF, 4'hF, 2'b11}));
    chk("reset_ma_busy", 32'({bus.ma, bus.busy}), 32'd0);

    // Byte write, bank 1, A[1:0]=10
    a = mk_addr(2'd1, 10'h2A3, 10'h155, 2'b10);
    push(10'h155, 4'b1101, 4'b1101, 1'b0);
    issue(a, 2'b01, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      @(negedge bclk);
      chk($sformatf("byte_wr_edge%0d", e), 32'({bus.ras, bus.cas, bus.we, bus.busy}),
          32'(bw_exp[e]));
      if (e == 1) chk("byte_wr_row_ma", 32'(bus.ma), 32'h2A3);
    end
    drain("byte_wr");

    // Line read, bank 2, A[3:2]=10: columns ..10, ..11, ..00, ..01
    do_reset();
    a = mk_addr(2'd2, 10'h0C3, 10'h2AE, 2'b00);
    push(10'h2AE, 4'h0, 4'b1011, 1'b1);
    push(10'h2AF, 4'h0, 4'b1011, 1'b1);
    push(10'h2AC, 4'h0, 4'b1011, 1'b1);
    push(10'h2AD, 4'h0, 4'b1011, 1'b1);
    issue(a, 2'b11, 1'b1);
    ras_lo = 0; cas_falls = 0; prev_cas = 4'hF;
    for (int i = 0; i < 30; i++) begin
      @(negedge bclk);
      if (bus.ras === 4'b1011) ras_lo++;
      if (bus.cas === 4'h0 && prev_cas !== 4'h0) cas_falls++;
      prev_cas = bus.cas;
    end
    chk("line_ras_low_cycles", 32'(ras_lo), 32'd12);
    chk("line_cas_pulses", 32'(cas_falls), 32'd4);
    drain("line_rd");

    // Single transfers: byte and (misaligned) word lanes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = mk_addr(2'd2, 10'h100, 10'h0F3, st_tab[i][5:4]);
      push(10'h0F3, st_tab[i][3:0], 4'b1011, 1'b1);
      issue(a, st_tab[i][7:6], 1'b1);
      drain($sformatf("single_%0d", i));
    end

    // Refresh with no traffic
    do_reset();
    k = 0;
    while (bus.cas !== 4'h0 && k < 600) begin
      @(negedge bclk);
      k++;
    end
    chk("ref_period", 32'(k), 32'd391);
    chk("ref_cas_before_ras", 32'({bus.ras, bus.cas}), 32'({4'hF, 4'h0}));
    for (int i = 1; i <= 3; i++) begin
      @(negedge bclk);
      chk($sformatf("ref_ras_low_%0d", i), 32'({bus.ras, bus.cas}), 32'd0);
    end
    @(negedge bclk);
    chk("ref_pre_1", 32'({bus.ras, bus.cas, bus.busy}), 32'({8'hFF, 1'b1}));
    @(negedge bclk);
    chk("ref_pre_2", 32'({bus.ras, bus.busy}), 32'({4'hF, 1'b1}));
    @(negedge bclk);
    chk("ref_idle", 32'(bus.busy), 32'd0);

    // TS coincides with refresh request: refresh first, then word write
    do_reset();
    repeat (389) @(negedge bclk);
    a = mk_addr(2'd0, 10'h111, 10'h0F0, 2'b00);
    push(10'h0F0, 4'b0011, 4'b1110, 1'b0);
    issue(a, 2'b10, 1'b0);
    @(negedge bclk);
    chk("tie_refresh_first", 32'({bus.ras, bus.cas}), 32'({4'hF, 4'h0}));
    drain("tie_word_wr");

    // Reset after beat 2 of a line read
    do_reset();
    a = mk_addr(2'd0, 10'h077, 10'h3FC, 2'b00);
    push(10'h3FC, 4'h0, 4'b1110, 1'b1);
    push(10'h3FD, 4'h0, 4'b1110, 1'b1);
    issue(a, 2'b11, 1'b1);
    tcnt = 0;
    for (int i = 0; i < 30 && tcnt < 2; i++) begin
      @(negedge bclk);
      if (bus.ta === 1'b0) tcnt++;
    end
    chk("rst_beats_seen", 32'(tcnt), 32'd2);
    rst = 1'b1;
    @(negedge bclk);
    chk("rst_mid_burst", 32'({bus.ras, bus.cas, bus.ta, bus.busy}), 32'({8'hFF, 2'b10}));
    rst   = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge bclk);
      if (bus.ta === 1'b0) extra++;
    end
    chk("rst_no_more_ta", 32'(extra), 32'd0);
    chk("rst_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back long reads, second TS sampled during PRE
    do_reset();
    push(10'h010, 4'h0, 4'b0111, 1'b1);
    push(10'h020, 4'h0, 4'b0111, 1'b1);
    issue(mk_addr(2'd3, 10'h05A, 10'h010, 2'b00), 2'b00, 1'b1);
    repeat (3) @(negedge bclk);
    issue(mk_addr(2'd3, 10'h05B, 10'h020, 2'b00), 2'b00, 1'b1);
    @(negedge bclk);
    chk("b2b_edge5_ras", 32'(bus.ras), 32'hF);
    @(negedge bclk);
    chk("b2b_edge6_idle", 32'({bus.ras, bus.busy}), 32'({4'hF, 1'b0}));
    @(negedge bclk);
    chk("b2b_edge7_ras", 32'({bus.ras, bus.ma}), 32'({4'b0111, 10'h05B}));
    drain("b2b");

    chk("sb_empty_final", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
